// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op encoding, unit FSM states and default datapath width.
package mips_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_v);
        return (op_v == OP_MULT) || (op_v == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_paso.sv
// One iteration of the multiply/divide datapath: shift-add (mode=0) or restoring subtract (mode=1)
// on an accumulator laid out as {upper[XLEN:0], lower[XLEN-1:0]}.
module mult_div_paso #(
    parameter int XLEN = 32
) (
    input  logic              mode,
    input  logic [2*XLEN:0]   acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN:0]   acc_out
);

    logic [XLEN:0]   upper_s;
    logic [XLEN-1:0] lower_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN+1:0] diff_s;

    assign upper_s   = acc_in[2*XLEN:XLEN];
    assign lower_s   = acc_in[XLEN-1:0];
    assign sum_s     = acc_in[0] ? (upper_s + {1'b0, operand}) : upper_s;
    assign shifted_s = {upper_s[XLEN-1:0], lower_s[XLEN-1]};
    assign diff_s    = {1'b0, shifted_s} - {2'b00, operand};

    // Select the step; a borrow out of the trial subtract restores the shifted remainder
    always_comb begin
        acc_out = acc_in;
        if (mode) begin
            if (diff_s[XLEN+1]) begin
                acc_out = {shifted_s, lower_s[XLEN-2:0], 1'b0};
            end else begin
                acc_out = {diff_s[XLEN:0], lower_s[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_out = {1'b0, sum_s, lower_s[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/unidad_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; operations run on unsigned magnitudes with a final sign fix.
// Optional MULTDIV_FAST_ZERO_EN: zero multiply operands or a zero dividend skip straight to FIX.
module unidad_mult_div
    import mips_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? ((~x) + XLEN'(1)) : x;
    endfunction

    state_t state_r, state_n;

    logic [CNT_W-1:0]  count_r, count_n;
    logic [1:0]        op_r, op_n;
    logic [2*XLEN:0]   acc_r, acc_n;
    logic [XLEN-1:0]   opnd_r, opnd_n;
    logic [XLEN-1:0]   rs_orig_r, rs_orig_n;
    logic              neg_q_r, neg_q_n;
    logic              neg_rem_r, neg_rem_n;
    logic              div0_r, div0_n;
    logic              zero_r, zero_n;
    logic [XLEN-1:0]   hi_r, hi_n;
    logic [XLEN-1:0]   lo_r, lo_n;
    logic              done_r, done_n;
    logic              busy_r;

    logic              sign_a_s, sign_b_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic              fast_zero_s;
    logic [2*XLEN:0]   step_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign sign_a_s = op_is_signed(op) & rs_data[XLEN-1];
    assign sign_b_s = op_is_signed(op) & rt_data[XLEN-1];
    assign mag_a_s  = op_is_signed(op) ? magnitude(rs_data) : rs_data;
    assign mag_b_s  = op_is_signed(op) ? magnitude(rt_data) : rt_data;

`ifdef MULTDIV_FAST_ZERO_EN
    assign fast_zero_s = op_is_div(op) ? ((rs_data == {XLEN{1'b0}}) && (rt_data != {XLEN{1'b0}}))
                                       : ((rs_data == {XLEN{1'b0}}) || (rt_data == {XLEN{1'b0}}));
`else
    assign fast_zero_s = 1'b0;
`endif

    assign prod_s = acc_r[2*XLEN-1:0];
    assign quo_s  = acc_r[XLEN-1:0];
    assign rem_s  = acc_r[2*XLEN-1:XLEN];

    mult_div_paso #(.XLEN(XLEN)) u_paso (
        .mode    (op_is_div(op_r)),
        .acc_in  (acc_r),
        .operand (opnd_r),
        .acc_out (step_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n = fast_zero_s ? FIX : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (count_r == CNT_W'(XLEN - 1)) begin
                    state_n = FIX;
                end else begin
                    state_n = RUN;
                end
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath and output next values; HI/LO only move in FIX
    always_comb begin
        count_n   = count_r;
        op_n      = op_r;
        acc_n     = acc_r;
        opnd_n    = opnd_r;
        rs_orig_n = rs_orig_r;
        neg_q_n   = neg_q_r;
        neg_rem_n = neg_rem_r;
        div0_n    = div0_r;
        zero_n    = zero_r;
        hi_n      = hi_r;
        lo_n      = lo_r;
        done_n    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    op_n      = op;
                    rs_orig_n = rs_data;
                    neg_q_n   = sign_a_s ^ sign_b_s;
                    neg_rem_n = sign_a_s;
                    div0_n    = op_is_div(op) && (rt_data == {XLEN{1'b0}});
                    zero_n    = fast_zero_s;
                    count_n   = {CNT_W{1'b0}};
                    if (op_is_div(op)) begin
                        acc_n  = {{(XLEN+1){1'b0}}, mag_a_s};
                        opnd_n = mag_b_s;
                    end else begin
                        acc_n  = {{(XLEN+1){1'b0}}, mag_b_s};
                        opnd_n = mag_a_s;
                    end
                end else begin
                    count_n = count_r;
                end
            end
            RUN: begin
                acc_n   = step_s;
                count_n = count_r + CNT_W'(1);
            end
            FIX: begin
                done_n  = 1'b1;
                count_n = {CNT_W{1'b0}};
                if (zero_r) begin
                    hi_n = {XLEN{1'b0}};
                    lo_n = {XLEN{1'b0}};
                end else if (div0_r) begin
                    hi_n = rs_orig_r;
                    lo_n = {XLEN{1'b1}};
                end else if (op_is_div(op_r)) begin
                    hi_n = neg_rem_r ? ((~rem_s) + XLEN'(1)) : rem_s;
                    lo_n = neg_q_r   ? ((~quo_s) + XLEN'(1)) : quo_s;
                end else begin
                    {hi_n, lo_n} = neg_q_r ? ((~prod_s) + (2*XLEN)'(1)) : prod_s;
                end
            end
            default: begin
                count_n = {CNT_W{1'b0}};
            end
        endcase
    end

    // Working registers, HI/LO and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= {CNT_W{1'b0}};
            op_r      <= 2'b00;
            acc_r     <= {(2*XLEN+1){1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            rs_orig_r <= {XLEN{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            zero_r    <= 1'b0;
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            count_r   <= count_n;
            op_r      <= op_n;
            acc_r     <= acc_n;
            opnd_r    <= opnd_n;
            rs_orig_r <= rs_orig_n;
            neg_q_r   <= neg_q_n;
            neg_rem_r <= neg_rem_n;
            div0_r    <= div0_n;
            zero_r    <= zero_n;
            hi_r      <= hi_n;
            lo_r      <= lo_n;
            done_r    <= done_n;
            busy_r    <= (state_n != IDLE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
